cmp_share_arbiter: RTL and testbench

//  Shares one WIDTH-bit magnitude comparator between two requesters.

---
 rtl/cmp_share_arbiter_pkg.sv | 31 +++
 rtl/cmp_share_arbiter_seg_hold_display.sv | 49 ++++
 rtl/cmp_share_arbiter.sv | 117 +++++++++++
 tb/tb_cmp_share_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_share_arbiter_pkg.sv
// Shared encodings for the comparator-sharing arbiter: FSM states, result codes
// and 7-segment patterns.
package cmp_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] RSP_EQ = 2'b00;
  localparam logic [1:0] RSP_GT = 2'b01;
  localparam logic [1:0] RSP_LT = 2'b10;

  localparam logic [6:0] SEG_GT    = 7'b1100110;
  localparam logic [6:0] SEG_LT    = 7'b1110010;
  localparam logic [6:0] SEG_EQ    = 7'b1110110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_of(input logic [1:0] code);
    logic [6:0] seg;
    case (code)
      RSP_GT:  seg = SEG_GT;
      RSP_LT:  seg = SEG_LT;
      RSP_EQ:  seg = SEG_EQ;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/cmp_share_arbiter_seg_hold_display.sv
// Shows the latest comparison result on the 7-segment display and blanks it
// HOLD_CYCLES cycles after the most recent load (HOLD_CYCLES=0 holds forever).
module seg_hold_display
  import cmp_share_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [1:0] code_i,
  output logic [6:0] led_o
);

  localparam int unsigned CW_RAW   = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned CW       = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam int unsigned LOAD_INT = (HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_INT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    led_q, led_d;

  // The load cycle counts as the first displayed cycle, hence HOLD_CYCLES-1.
  always_comb begin
    cnt_d = cnt_q;
    led_d = led_q;
    if (load_i) begin
      led_d = seg_of(code_i);
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else if (HOLD_CYCLES != 0) begin
      led_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      led_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one unsigned magnitude comparator between two
// valid/ready requesters; drives the status 7-segment display with the result.
module cmp_share_arbiter
  import cmp_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned HOLD_CYCLES = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [1:0]       rsp_code,
  output logic [6:0]       led,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       rsp_code_q, rsp_code_d;
  logic [1:0]       cmp_code;
  logic             grant;
  logic             accept;
  logic             rsp_done;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    accept = rst_n && (state_q == ST_IDLE) && (req0_valid || req1_valid);
  end

  always_comb begin
    if (a_q > b_q)      cmp_code = RSP_GT;
    else if (a_q < b_q) cmp_code = RSP_LT;
    else                cmp_code = RSP_EQ;
  end

  assign rsp_done = owner_q ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)   state_d = ST_CMP;
      ST_CMP:                state_d = ST_RESP;
      ST_RESP: if (rsp_done) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    rsp0_valid = (state_q == ST_RESP) && !owner_q;
    rsp1_valid = (state_q == ST_RESP) && owner_q;
    busy       = (state_q != ST_IDLE);
    rsp_code   = rsp_code_q;
  end

  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rsp_code_d   = rsp_code_q;
    if (accept) begin
      a_d          = grant ? req1_a : req0_a;
      b_d          = grant ? req1_b : req0_b;
      owner_d      = grant;
      last_grant_d = grant;
    end
    if (state_q == ST_CMP) rsp_code_d = cmp_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_code_q   <= RSP_EQ;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rsp_code_q   <= rsp_code_d;
    end
  end

  seg_hold_display #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_display (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_q == ST_CMP),
    .code_i (cmp_code),
    .led_o  (led)
  );

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter: table of single transactions plus
// hand-written arbitration, back-pressure, display-hold and reset sequences.
module tb_cmp_share_arbiter;

  localparam logic [1:0] C_EQ = 2'b00;
  localparam logic [1:0] C_GT = 2'b01;
  localparam logic [1:0] C_LT = 2'b10;
  localparam logic [6:0] L_GT = 7'b1100110;
  localparam logic [6:0] L_LT = 7'b1110010;
  localparam logic [6:0] L_EQ = 7'b1110110;
  localparam logic [6:0] L_BL = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [1:0] rsp_code;
  logic [6:0] led;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cmp_share_arbiter #(
    .WIDTH(4),
    .HOLD_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_code   (rsp_code),
    .led        (led),
    .busy       (busy)
  );

  typedef struct {
    int         r;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] code;
    logic [6:0] led;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 32'(0));
    check({tag, "_rdy0"},  32'(req0_ready), 32'(0));
    check({tag, "_rdy1"},  32'(req1_ready), 32'(0));
    check({tag, "_rsp0v"}, 32'(rsp0_valid), 32'(0));
    check({tag, "_rsp1v"}, 32'(rsp1_valid), 32'(0));
    check({tag, "_code"},  32'(rsp_code), 32'(C_EQ));
    check({tag, "_led"},   32'(led), 32'(L_BL));
  endtask

  // One complete transaction with the response consumed immediately.
  task automatic run_txn(input string name, input int r, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] ec, input logic [6:0] el);
    @(negedge clk);
    if (r == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    else        begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    #1;
    check({name, "_ready"}, 32'(r == 0 ? req0_ready : req1_ready), 32'(1));
    check({name, "_other_ready"}, 32'(r == 0 ? req1_ready : req0_ready), 32'(0));
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check({name, "_cmp_busy"}, 32'(busy), 32'(1));
    check({name, "_cmp_rspv"}, 32'(rsp0_valid | rsp1_valid), 32'(0));
    @(negedge clk);
    check({name, "_rspv"}, 32'(r == 0 ? rsp0_valid : rsp1_valid), 32'(1));
    check({name, "_other_rspv"}, 32'(r == 0 ? rsp1_valid : rsp0_valid), 32'(0));
    check({name, "_code"}, 32'(rsp_code), 32'(ec));
    check({name, "_led"}, 32'(led), 32'(el));
    $display("txn %s: req%0d a=%0h b=%0h code=%b led=%b", name, r, a, b, rsp_code, led);
    if (r == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #1;
    check({name, "_idle"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int grants;
    int exp_g;

    vecs[0] = '{0, 4'd9, 4'd3, C_GT, L_GT};
    vecs[1] = '{1, 4'hF, 4'hF, C_EQ, L_EQ};
    vecs[2] = '{0, 4'h0, 4'hF, C_LT, L_LT};
    vecs[3] = '{1, 4'd3, 4'd9, C_LT, L_LT};
    vecs[4] = '{0, 4'd7, 4'd7, C_EQ, L_EQ};
    vecs[5] = '{1, 4'hF, 4'h0, C_GT, L_GT};
    vecs[6] = '{0, 4'd8, 4'd7, C_GT, L_GT};
    vecs[7] = '{1, 4'h0, 4'h0, C_EQ, L_EQ};

    // Reset
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_reset_outputs("post_reset");

    // Both requesters valid from reset: req0 first, then strict alternation.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd3;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd5;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    grants = 0;
    exp_g  = 0;
    for (int c = 0; c < 30 && grants < 4; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        check("arb_grant", 32'(req1_ready), 32'(exp_g));
        check("arb_excl", 32'(req0_ready & req1_ready), 32'(0));
        $display("txn arb: grant to req%0d", req1_ready);
        exp_g = 1 - exp_g;
        grants++;
      end
      if (rsp0_valid) check("arb_rsp0_code", 32'(rsp_code), 32'(C_GT));
      if (rsp1_valid) check("arb_rsp1_code", 32'(rsp_code), 32'(C_LT));
      if (grants < 4) @(negedge clk);
    end
    check("arb_grant_count", 32'(grants), 32'(4));
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #1 check("arb_drain_idle", 32'(busy), 32'(0));

    // Table of single transactions
    for (int i = 0; i < 8; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].code, vecs[i].led);

    // Response back-pressure: req0 result held 20 cycles, req1 locked out.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2;
    rsp1_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd6;
    #1 check("bp_cmp_rdy1", 32'(req1_ready), 32'(0));
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      #1;
      check("bp_rsp0v", 32'(rsp0_valid), 32'(1));
      check("bp_code", 32'(rsp_code), 32'(C_LT));
      check("bp_busy", 32'(busy), 32'(1));
      check("bp_rdy1", 32'(req1_ready), 32'(0));
      check("bp_rsp1v", 32'(rsp1_valid), 32'(0));
      @(negedge clk);
    end
    $display("txn bp: req0 a=1 b=2 held 20 cycles code=%b", rsp_code);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1 check("bp_rdy1_after", 32'(req1_ready), 32'(1));
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    check("bp_rsp1v_after", 32'(rsp1_valid), 32'(1));
    check("bp_rsp1_code", 32'(rsp_code), 32'(C_EQ));
    $display("txn bp: req1 a=6 b=6 code=%b", rsp_code);
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1 check("bp_idle", 32'(busy), 32'(0));

    // Display hold: visible for exactly 8 cycles from load, then blank.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd5;
    @(negedge clk);
    req0_valid = 1'b0;
    rsp0_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      #1 check($sformatf("hold1_c%0d", c), 32'(led), 32'(c < 8 ? L_EQ : L_BL));
      @(negedge clk);
    end
    $display("txn hold1: EQ shown 8 cycles then blank");

    // Second result loaded 5 cycles after the first restarts the hold.
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd3;
    rsp1_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 15; c++) begin
      if (c == 3) begin req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd5; end
      if (c == 4) req1_valid = 1'b0;
      #1;
      if (c == 3) check("hold2_rdy1", 32'(req1_ready), 32'(1));
      check($sformatf("hold2_c%0d", c), 32'(led), 32'(c < 5 ? L_GT : (c < 13 ? L_LT : L_BL)));
      @(negedge clk);
    end
    $display("txn hold2: GT reloaded by LT at cycle 5, blank at cycle 13");
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Asynchronous reset during RESP, then a normal transaction.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd0; req0_b = 4'd1;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    #1 check("rst_pre_rsp0v", 32'(rsp0_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd3;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    req1_valid = 1'b0;
    rst_n = 1'b1;
    #1 check_reset_outputs("rst_release");
    run_txn("after_rst", 1, 4'hC, 4'h4, C_GT, L_GT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
